// File: rtl/pipe_rr_arbiter.sv
// Round-robin arbiter sharing one valid/ready pipeline input among NUM_REQ requesters.
// Optional per-owner burst priority is enabled by defining PIPE_ARB_BURST_EN.
module pipe_rr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4,
    localparam int SRC_W     = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [SRC_W-1:0]              out_src,
    output logic                          locked
);

    localparam logic ST_ARB  = 1'b0;
    localparam logic ST_HOLD = 1'b1;

    if (NUM_REQ < 2 || NUM_REQ > 16 || MAX_BURST < 1 || MAX_BURST > 255) begin : g_cfg_chk
        $error("pipe_rr_arbiter: parameter out of range");
    end

    logic             r_lock;
    logic [SRC_W-1:0] r_ptr;
    logic [SRC_W-1:0] r_lock_idx;
    logic [SRC_W-1:0] w_arb_idx;
    logic [SRC_W-1:0] w_grant;
    logic [SRC_W-1:0] w_sel;
    logic [SRC_W-1:0] w_grant_inc;
    logic [SRC_W-1:0] w_ptr_next;
    logic             w_valid;
    logic             w_hs;
    logic             w_stall;

    // First valid requester at or after r_ptr, wrapping; falls back to r_ptr when none.
    always_comb begin
        logic found;
        found     = 1'b0;
        w_arb_idx = r_ptr;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            logic [SRC_W-1:0] idx;
            idx = SRC_W'((32'(r_ptr) + k) % NUM_REQ);
            if (!found && req_valid[idx]) begin
                w_arb_idx = idx;
                found     = 1'b1;
            end
        end
    end

    assign w_grant     = (r_lock == ST_HOLD) ? r_lock_idx : w_arb_idx;
    assign w_sel       = rst_n ? w_grant : '0;
    assign w_valid     = rst_n & req_valid[w_sel];
    assign w_hs        = w_valid & out_ready;
    assign w_stall     = w_valid & ~out_ready;
    assign w_grant_inc = (w_grant == SRC_W'(NUM_REQ - 1)) ? '0 : w_grant + SRC_W'(1);

    assign out_valid = w_valid;
    assign out_src   = w_sel;
    assign locked    = r_lock;

    always_comb begin
        out_data  = '0;
        req_ready = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (w_sel == SRC_W'(k)) begin
                out_data = req_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
            req_ready[k] = w_hs && (w_sel == SRC_W'(k));
        end
    end

`ifdef PIPE_ARB_BURST_EN
    logic [7:0]       r_burst_cnt;
    logic [7:0]       w_cnt_next;
    logic [SRC_W-1:0] r_owner;

    // The owner keeps priority until it has moved MAX_BURST consecutive beats.
    always_comb begin
        w_cnt_next = (w_grant == r_owner) ? r_burst_cnt + 8'd1 : 8'd1;
        w_ptr_next = (w_cnt_next < 8'(MAX_BURST)) ? w_grant : w_grant_inc;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_burst_cnt <= '0;
            r_owner     <= '0;
        end else if (w_hs) begin
            r_owner     <= w_grant;
            r_burst_cnt <= (w_cnt_next < 8'(MAX_BURST)) ? w_cnt_next : '0;
        end
    end
`else
    assign w_ptr_next = w_grant_inc;
`endif

    // A hold that ends without a handshake (requester dropped valid) leaves r_ptr untouched.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr      <= '0;
            r_lock     <= ST_ARB;
            r_lock_idx <= '0;
        end else if (w_hs) begin
            r_ptr  <= w_ptr_next;
            r_lock <= ST_ARB;
        end else if (w_stall) begin
            r_lock     <= ST_HOLD;
            r_lock_idx <= w_grant;
        end else begin
            r_lock <= ST_ARB;
        end
    end

endmodule
